// File: rtl/ctrl_pkg.sv
// Shared run-control types and default widths for the core's fetch path,
// sequencer and top level.
package ctrl_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prog_ctrl.sv
// Run-control sequencer: owns the PC, the req/done start-finish handshake,
// the architectural write gate and the run statistics.
module prog_ctrl
  import ctrl_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             br_rel,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output state_t           state
);

  // A limit beyond the counter range can never be reached, so it disables
  // the watchdog just like MAX_CYCLES = 0.
  localparam bit WD_EN = (MAX_CYCLES > 0) &&
                         (longint'(MAX_CYCLES) <= (longint'(1) << CNT_W));
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? MAX_CYCLES - 1 : 0);

  // Handshake: a req pulse (even one shared with reset) arms the sequencer;
  // the run starts once req is low, and done stays high until the next
  // start or reset. req during a run only arms the next run.
  state_t           state_q;
  logic             armed;
  logic             start;
  logic             wd_hit;
  logic             cyc_en;
  logic             ins_en;
  logic [PC_W-1:0]  pc_next;

  assign start  = (state_q != RUN) && armed && !req;
  assign wd_hit = WD_EN && (cycle_count == WD_LAST);
  assign cyc_en = (state_q == RUN) && !wd_hit;
  assign ins_en = (state_q == RUN) && !wd_hit && !stall;
  assign state  = state_q;

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (br_taken) begin
      pc_next = br_rel ? (pc + br_target) : br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed   <= req;
      pc      <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (req) begin
        armed <= 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            armed   <= 1'b0;
            pc      <= '0;
            run     <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        RUN: begin
          if (wd_hit) begin
            state_q <= DONE;
            run     <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (stall) begin
            pc <= pc;
          end else if (halt) begin
            state_q <= DONE;
            run     <= 1'b0;
            done    <= 1'b1;
          end else begin
            pc <= pc_next;
          end
        end
        default: begin
          state_q <= IDLE;
          run     <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clear (reset || start),
    .en    (cyc_en),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clear (reset || start),
    .en    (ins_en),
    .count (instr_count)
  );

endmodule

// File: tb/tb_prog_ctrl.sv
// Bench for prog_ctrl: three configurations share one stimulus stream and
// are each checked every cycle against a reference model of the run rules.
module tb_prog_ctrl;
  import ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       req = 1'b1;
  logic       halt = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic       br_rel = 1'b0;
  logic [9:0] br_target = '0;

  // a: default widths, watchdog 200; w: 4-bit pc, 5-bit counters, no
  // watchdog; d: default widths, watchdog 8
  logic [9:0]  pc_a, pc_d;
  logic [3:0]  pc_w;
  logic        run_a, run_w, run_d, done_a, done_w, done_d;
  logic        to_a, to_w, to_d;
  logic [15:0] cyc_a, ins_a, cyc_d, ins_d;
  logic [4:0]  cyc_w, ins_w;
  state_t      st_a, st_w, st_d;

  prog_ctrl #(.PC_W(10), .CNT_W(16), .MAX_CYCLES(200)) dut_a (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .stall(stall),
    .br_taken(br_taken), .br_rel(br_rel), .br_target(br_target),
    .pc(pc_a), .run(run_a), .done(done_a), .timeout(to_a),
    .cycle_count(cyc_a), .instr_count(ins_a), .state(st_a));

  prog_ctrl #(.PC_W(4), .CNT_W(5), .MAX_CYCLES(0)) dut_w (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .stall(stall),
    .br_taken(br_taken), .br_rel(br_rel), .br_target(br_target[3:0]),
    .pc(pc_w), .run(run_w), .done(done_w), .timeout(to_w),
    .cycle_count(cyc_w), .instr_count(ins_w), .state(st_w));

  prog_ctrl #(.PC_W(10), .CNT_W(16), .MAX_CYCLES(8)) dut_d (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .stall(stall),
    .br_taken(br_taken), .br_rel(br_rel), .br_target(br_target),
    .pc(pc_d), .run(run_d), .done(done_d), .timeout(to_d),
    .cycle_count(cyc_d), .instr_count(ins_d), .state(st_d));

  // ---------------- reference model ----------------
  typedef struct {
    int     phase;   // 0 idle, 1 running, 2 finished
    bit     armed;
    longint pc;
    longint cyc;
    longint ins;
    bit     timeout;
  } mdl_t;

  mdl_t ma, mw, md;
  bit   checking = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic mdl_t step(mdl_t m, bit rst, bit rq, bit hl, bit st,
                                bit bt, bit br, longint tgt,
                                int pw, int cw, int maxc);
    longint pmod = longint'(1) << pw;
    longint smax = (longint'(1) << cw) - 1;
    longint t = tgt % pmod;
    mdl_t n = m;
    if (rst) begin
      n.phase = 0; n.armed = rq; n.pc = 0; n.cyc = 0; n.ins = 0; n.timeout = 0;
      return n;
    end
    if (rq) n.armed = 1;
    if (m.phase != 1 && m.armed && !rq) begin
      n.phase = 1; n.armed = 0; n.pc = 0; n.cyc = 0; n.ins = 0; n.timeout = 0;
    end else if (m.phase == 1) begin
      if (maxc != 0 && m.cyc == maxc - 1) begin
        n.phase = 2; n.timeout = 1;
      end else begin
        n.cyc = (m.cyc < smax) ? m.cyc + 1 : smax;
        if (!st) begin
          n.ins = (m.ins < smax) ? m.ins + 1 : smax;
          if (hl) n.phase = 2;
          else if (bt) n.pc = br ? (m.pc + t) % pmod : t;
          else n.pc = (m.pc + 1) % pmod;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, reset, req, halt, stall, br_taken, br_rel, longint'(br_target), 10, 16, 200);
    mw = step(mw, reset, req, halt, stall, br_taken, br_rel, longint'(br_target), 4, 5, 0);
    md = step(md, reset, req, halt, stall, br_taken, br_rel, longint'(br_target), 10, 16, 8);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [63:0] p,
                     input logic r, input logic d, input logic to,
                     input logic [63:0] c, input logic [63:0] i);
    check({tag, ".pc"}, p, 64'(m.pc));
    check({tag, ".run"}, 64'(r), 64'(m.phase == 1));
    check({tag, ".done"}, 64'(d), 64'(m.phase == 2));
    check({tag, ".timeout"}, 64'(to), 64'(m.timeout));
    check({tag, ".cycle_count"}, c, 64'(m.cyc));
    check({tag, ".instr_count"}, i, 64'(m.ins));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp("a", ma, 64'(pc_a), run_a, done_a, to_a, 64'(cyc_a), 64'(ins_a));
      cmp("w", mw, 64'(pc_w), run_w, done_w, to_w, 64'(cyc_w), 64'(ins_w));
      cmp("d", md, 64'(pc_d), run_d, done_d, to_d, 64'(cyc_d), 64'(ins_d));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start_run();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
  endtask

  task automatic halt_now();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // req shares the reset net for two cycles
    ticks(2);
    checking = 1'b1;
    @(negedge clk);
    check("rst.pc", 64'(pc_a), 0);
    check("rst.run", 64'(run_a), 0);
    check("rst.done", 64'(done_a), 0);
    check("rst.cycle", 64'(cyc_a), 0);
    reset = 1'b0;
    req = 1'b0;
    tick();
    @(negedge clk);
    check("start.run", 64'(run_a), 1);
    check("start.pc", 64'(pc_a), 0);
    ticks(5);
    halt_now();
    @(negedge clk);
    check("seq.done", 64'(done_a), 1);
    check("seq.pc", 64'(pc_a), 5);
    check("seq.instr", 64'(ins_a), 6);
    check("seq.cycle", 64'(cyc_a), 6);
    check("seq.timeout", 64'(to_a), 0);

    // absolute then relative branch
    start_run();
    ticks(3);
    br_taken = 1'b1; br_rel = 1'b0; br_target = 10'd40;
    tick();
    @(negedge clk);
    check("br.abs", 64'(pc_a), 40);
    br_rel = 1'b1; br_target = 10'h3ff;
    tick();
    @(negedge clk);
    check("br.rel", 64'(pc_a), 39);
    br_taken = 1'b0; br_rel = 1'b0; br_target = '0;
    halt_now();

    // stall masks halt
    start_run();
    ticks(2);
    stall = 1'b1; halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("stall.pc", 64'(pc_a), 2);
      check("stall.done", 64'(done_a), 0);
    end
    stall = 1'b0;
    tick();
    halt = 1'b0;
    @(negedge clk);
    check("stall.halt_done", 64'(done_a), 1);
    check("stall.cycle", 64'(cyc_a), 6);
    check("stall.instr", 64'(ins_a), 3);

    // 4-bit pc wraps
    start_run();
    ticks(16);
    @(negedge clk);
    check("wrap.pc0", 64'(pc_w), 0);
    tick();
    @(negedge clk);
    check("wrap.pc1", 64'(pc_w), 1);
    check("wrap.instr", 64'(ins_w), 17);
    halt_now();

    // watchdog of 8
    start_run();
    ticks(7);
    @(negedge clk);
    check("wd.still_run", 64'(run_d), 1);
    tick();
    @(negedge clk);
    check("wd.done", 64'(done_d), 1);
    check("wd.timeout", 64'(to_d), 1);
    check("wd.cycle", 64'(cyc_d), 7);
    halt_now();

    // reset mid-run, then restart after done
    start_run();
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst.pc", 64'(pc_a), 0);
    check("mid_rst.run", 64'(run_a), 0);
    check("mid_rst.instr", 64'(ins_a), 0);
    tick();
    @(negedge clk);
    check("mid_rst.idle", 64'(run_a), 0);
    start_run();
    halt_now();
    start_run();
    @(negedge clk);
    check("restart.pc", 64'(pc_a), 0);
    check("restart.done", 64'(done_a), 0);
    check("restart.run", 64'(run_a), 1);

    // req during run does not abort; next run follows done
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    @(negedge clk);
    check("req_in_run.run", 64'(run_a), 1);
    halt_now();
    @(negedge clk);
    check("req_in_run.done", 64'(done_a), 1);
    tick();
    @(negedge clk);
    check("req_in_run.rerun", 64'(run_a), 1);
    check("req_in_run.pc", 64'(pc_a), 0);

    // randomized traffic; halt-free epochs exercise watchdog and saturation
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req       = ($urandom_range(0, 29) == 0);
      halt      = ((i % 1000) < 600) ? ($urandom_range(0, 24) == 0) : 1'b0;
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      br_rel    = 1'($urandom_range(0, 1));
      br_target = 10'($urandom_range(0, 1023));
      tick();
    end
    reset = 1'b0; req = 1'b0; halt = 1'b0; stall = 1'b0; br_taken = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
